iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
Multi-cycle shift sequencer for the 32-bit MIPS datapath. It implements the SLL/SRL/SRA/ROTR family with the full 5-bit shift amount by iterating a 0..3-bit-per-cycle shift step. It sits beside the ALU in the EX stage. The pipeline control launches it with start/in_data/shamt/op and stalls on busy until done pulses with the result.

Parameters:
WIDTH, 32, datapath width in bits.
SHAMT_W, 5, shift-amount width (log2 WIDTH).
STEP_MAX, 3, maximum bits shifted per iteration (2-bit step encoding).

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request strobe; sampled only in IDLE.
in_data  input  WIDTH  operand (rt).
shamt  input  SHAMT_W  shift amount 0..31.
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle completion pulse.
out_data  output  WIDTH  result; valid when done=1, held until the next completion.

Behaviour:
- States: IDLE, SHIFT. Internal registers: acc[WIDTH], rem[SHAMT_W], op_q[2].
- Reset (rst_n=0, any time, asynchronous): state=IDLE, busy=0, done=0, out_data=0, acc=0, rem=0. An in-flight operation is discarded with no done pulse.
- IDLE, start=1 at edge E0:
  - acc<=in_data, rem<=shamt, op_q<=op.
  - busy<=1, state<=SHIFT.
  - in_data, shamt and op are not required to stay stable after E0.
- SHIFT, rem!=0 at an edge:
  - step = (rem>=3) ? 3 : rem.
  - acc <= shift(acc, step, op_q); rem <= rem-step.
- SHIFT, rem==0 at an edge:
  - out_data<=acc, done<=1, busy<=0, state<=IDLE.
- Shift rules:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: replicate acc[WIDTH-1]. Iterative SRA equals a single shift of the original operand.
  - ROTR: bits leaving the LSB enter the MSB.
- Latency: N=ceil(shamt/3). done is high in the cycle after edge E(N+1).
  - shamt=0 gives done after E1.
  - shamt=31 gives N=11, done after E12.
- busy is high from after E0 through the cycle before done. busy and done are never both 1.
- done is high for exactly one cycle, then returns to 0. out_data keeps its value.
- start while busy=1 is ignored: no queuing, no effect on the running operation.
- start asserted in the done cycle is accepted, because the state is already IDLE. Back-to-back operations need no idle gap.
- start held high continuously launches a new operation on every IDLE edge.
- There is no X-propagation dependence: all outputs are registered and have defined reset values.

Test Plan:
- SLL, in_data=0x0000_0001, shamt=31 -> out_data=0x8000_0000; done after edge E12; busy high for 12 cycles.
- SRA, in_data=0x8000_00F0, shamt=4 -> 0xF800_000F, done after E3. Same stimulus with SRL -> 0x0800_000F.
- ROTR, in_data=0x0000_0003, shamt=1 -> 0x8000_0001, done after E2. Any op with shamt=0, in_data=0xDEAD_BEEF -> 0xDEAD_BEEF, done after E1.
- Second start pulse (SLL, in_data=0xFFFF_FFFF, shamt=5) issued while busy -> ignored; first result unchanged. New start in the done cycle -> accepted; its done arrives N+1 cycles later.
- rst_n driven low mid-SHIFT (SRL, shamt=20, at E3) -> busy=0, done=0, out_data=0 immediately without a clock edge. No done pulse follows after release.
- Randomized sweep of shamt 0..31 and all 4 ops against a reference model -> out_data matches every case; latency equals ceil(shamt/3)+1 edges.

Source files
------------

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTR sequencer for the EX stage.
// Each cycle it shifts by up to STEP_MAX bits until the remaining amount reaches zero.
module iter_shift_unit #(
  parameter int WIDTH    = 32,
  parameter int SHAMT_W  = 5,
  parameter int STEP_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_data
);

  localparam int STEP_W = $clog2(STEP_MAX + 1);

  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROTR = 2'b11} op_e;
  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  typedef struct packed {
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data;
  } req_t;

  state_e             state_q;
  req_t               req;
  logic [WIDTH-1:0]   acc_q, acc_d, out_q;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q;
  logic               busy_q, done_q;
  logic [STEP_W-1:0]  step;
  logic [SHAMT_W:0]   rot_amt;

  assign req = '{op: op, shamt: shamt, data: in_data};

  always_comb begin
    step    = (rem_q >= SHAMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];
    rem_d   = rem_q - SHAMT_W'(step);
    // For step==0 the left shift by WIDTH yields zero, so ROTR degenerates cleanly.
    rot_amt = (SHAMT_W+1)'(WIDTH) - (SHAMT_W+1)'(step);
    acc_d   = acc_q;
    case (op_e'(op_q))
      OP_SLL:  acc_d = acc_q << step;
      OP_SRL:  acc_d = acc_q >> step;
      OP_SRA:  acc_d = $signed(acc_q) >>> step;
      OP_ROTR: acc_d = (acc_q >> step) | (acc_q << rot_amt);
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q   <= req.data;
            rem_q   <= req.shamt;
            op_q    <= req.op;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (rem_q != '0) begin
            acc_q <= acc_d;
            rem_q <= rem_d;
          end else begin
            out_q   <= acc_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: expected result/latency queued at launch, popped on done.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] in_data;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        busy, done;
  logic [31:0] out_data;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  iter_shift_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .shamt(shamt), .op(op),
    .busy(busy), .done(done), .out_data(out_data)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int sh);
    case (o)
      2'd0:    return d << sh;
      2'd1:    return d >> sh;
      2'd2:    return 32'($signed(d) >>> sh);
      default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
    endcase
  endfunction

  task automatic drive_start(input logic [1:0] o, input logic [31:0] d, input logic [4:0] sh);
    exp_t e;
    start = 1'b1; op = o; in_data = d; shamt = sh;
    e.data = ref_shift(o, d, int'(sh));
    e.lat  = (int'(sh) + 2) / 3 + 1;
    sb.push_back(e);
  endtask

  // Returns at the negedge of the done cycle; lat counts edges after the launch edge.
  task automatic wait_done(input int inj, output logic [31:0] res, output int lat,
                           output int bcyc, output bit both);
    res = 'x; lat = -1; bcyc = 0; both = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (busy && done) both = 1'b1;
      if (done) begin
        res = out_data; lat = k;
        return;
      end
      if (busy) bcyc++;
      if (k == inj) begin
        start = 1'b1; op = 2'b00; in_data = 32'hFFFF_FFFF; shamt = 5'd5;
      end
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'h0) $display("FAIL reset_out got %h exp 0", out_data); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sll31();
    logic [31:0] res; int lat, bcyc; bit both; exp_t e;
    drive_start(2'b00, 32'h0000_0001, 5'd31);
    wait_done(-1, res, lat, bcyc, both);
    e = sb.pop_front();
    chk_cnt++; if (res !== e.data) $display("FAIL sll31_data got %h exp %h", res, e.data); else pass_cnt++;
    chk_cnt++; if (lat !== e.lat) $display("FAIL sll31_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
    chk_cnt++; if (bcyc !== 12) $display("FAIL sll31_busy_cycles got %0d exp 12", bcyc); else pass_cnt++;
    chk_cnt++; if (both !== 1'b0) $display("FAIL sll31_busy_and_done got %b exp 0", both); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0) $display("FAIL done_one_cycle got %b exp 0", done); else pass_cnt++;
    chk_cnt++; if (out_data !== e.data) $display("FAIL out_hold got %h exp %h", out_data, e.data); else pass_cnt++;
  endtask

  task automatic test_sra_srl();
    logic [31:0] res; int lat, bcyc; bit both; exp_t e;
    drive_start(2'b10, 32'h8000_00F0, 5'd4);
    wait_done(-1, res, lat, bcyc, both);
    e = sb.pop_front();
    chk_cnt++; if (res !== e.data) $display("FAIL sra4_data got %h exp %h", res, e.data); else pass_cnt++;
    chk_cnt++; if (lat !== e.lat) $display("FAIL sra4_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
    drive_start(2'b01, 32'h8000_00F0, 5'd4);
    wait_done(-1, res, lat, bcyc, both);
    e = sb.pop_front();
    chk_cnt++; if (res !== e.data) $display("FAIL srl4_data got %h exp %h", res, e.data); else pass_cnt++;
    chk_cnt++; if (lat !== e.lat) $display("FAIL srl4_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
  endtask

  task automatic test_rotr_zero();
    logic [31:0] res; int lat, bcyc; bit both; exp_t e;
    drive_start(2'b11, 32'h0000_0003, 5'd1);
    wait_done(-1, res, lat, bcyc, both);
    e = sb.pop_front();
    chk_cnt++; if (res !== e.data) $display("FAIL rotr1_data got %h exp %h", res, e.data); else pass_cnt++;
    chk_cnt++; if (lat !== e.lat) $display("FAIL rotr1_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
    for (int o = 0; o < 4; o++) begin
      drive_start(2'(o), 32'hDEAD_BEEF, 5'd0);
      wait_done(-1, res, lat, bcyc, both);
      e = sb.pop_front();
      chk_cnt++; if (res !== e.data) $display("FAIL zero_op%0d_data got %h exp %h", o, res, e.data); else pass_cnt++;
      chk_cnt++; if (lat !== e.lat) $display("FAIL zero_op%0d_lat got %0d exp %0d", o, lat, e.lat); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat, bcyc; bit both; exp_t e;
    drive_start(2'b01, 32'h1234_5678, 5'd9);
    wait_done(1, res, lat, bcyc, both);
    e = sb.pop_front();
    chk_cnt++; if (res !== e.data) $display("FAIL ignore_busy_data got %h exp %h", res, e.data); else pass_cnt++;
    chk_cnt++; if (lat !== e.lat) $display("FAIL ignore_busy_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
    drive_start(2'b11, 32'hDEAD_BEEF, 5'd7);
    wait_done(-1, res, lat, bcyc, both);
    e = sb.pop_front();
    chk_cnt++; if (res !== e.data) $display("FAIL b2b_data got %h exp %h", res, e.data); else pass_cnt++;
    chk_cnt++; if (lat !== e.lat) $display("FAIL b2b_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    exp_t e; bit seen;
    drive_start(2'b01, 32'hA5A5_0F0F, 5'd20);
    e = sb.pop_front();
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b exp 1", busy); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL mid_reset_done got %b exp 0", done); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'h0) $display("FAIL mid_reset_out got %h exp 0", out_data); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL mid_reset_quiet got %b exp 0 (discarded: %h)", seen, e.data); else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [31:0] res; int lat, bcyc; bit both; exp_t e;
    for (int o = 0; o < 4; o++) begin
      for (int sh = 0; sh < 32; sh++) begin
        drive_start(2'(o), $urandom, 5'(sh));
        wait_done(-1, res, lat, bcyc, both);
        e = sb.pop_front();
        chk_cnt++; if (res !== e.data) $display("FAIL sweep_op%0d_sh%0d_data got %h exp %h", o, sh, res, e.data); else pass_cnt++;
        chk_cnt++; if (lat !== e.lat) $display("FAIL sweep_op%0d_sh%0d_lat got %0d exp %0d", o, sh, lat, e.lat); else pass_cnt++;
        chk_cnt++; if (both !== 1'b0) $display("FAIL sweep_op%0d_sh%0d_overlap got %b exp 0", o, sh, both); else pass_cnt++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; in_data = '0; shamt = '0;
    test_reset();
    test_sll31();
    test_sra_srl();
    test_rotr_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
